// File: rtl/stacker_pkg.sv
// Block-stacker shared constants: screen geometry, coordinate and
// colour widths, block dimensions and frame timing defaults.
package stacker_pkg;

    localparam int X_MAX       = 160;
    localparam int Y_MAX       = 120;
    localparam int X_W         = 8;
    localparam int Y_W         = 7;
    localparam int COLOUR_W    = 3;
    localparam int BLK_W       = 16;
    localparam int BLK_H       = 4;
    localparam int FRAME_TICKS = 12_500_000;

    localparam logic [COLOUR_W-1:0] COLOUR_BLACK = '0;

endpackage

// File: rtl/rate_divider.sv
// Frame-rate delay counter: emits a one-cycle enable_erase pulse every
// FRAME_TICKS enabled cycles.
// Ports: clk, resetn (sync, active-high), reset_counter (active-low
// clear), enable_counter (advance), enable_erase (pulse out).
module rate_divider #(
    parameter int FRAME_TICKS = 12_500_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic reset_counter,
    input  logic enable_counter,
    output logic enable_erase
);

    localparam int W = $clog2(FRAME_TICKS > 1 ? FRAME_TICKS : 2);
    localparam logic [W-1:0] LAST = W'(FRAME_TICKS - 1);

    logic [W-1:0] dly_q;
    logic         pulse_q;

    always_ff @(posedge clk) begin
        if (resetn || !reset_counter) begin
            dly_q   <= '0;
            pulse_q <= 1'b0;
        end else if (enable_counter) begin
            if (dly_q == LAST) begin
                dly_q   <= '0;
                pulse_q <= 1'b1;
            end else begin
                dly_q   <= dly_q + 1'b1;
                pulse_q <= 1'b0;
            end
        end else begin
            pulse_q <= 1'b0;
        end
    end

    assign enable_erase = pulse_q;

endmodule

// File: rtl/block_datapath.sv
// Block-stacker datapath: block position/direction, pixel scan for
// plot/erase, frame tick divider and stop-key synchronizer.
// Ports: FSM strobes in (ld_x, ld_y, count_x_enable, colour_erase_enable,
// enable_counter, reset_counter, reset_load), colour_in, key_stop;
// VGA x_out/y_out/colour_out and status done_plot/enable_erase/stop_true.
module block_datapath #(
    parameter int BLOCK_W     = stacker_pkg::BLK_W,
    parameter int BLOCK_H     = stacker_pkg::BLK_H,
    parameter int X_MAX       = stacker_pkg::X_MAX,
    parameter int Y_MAX       = stacker_pkg::Y_MAX,
    parameter int FRAME_TICKS = stacker_pkg::FRAME_TICKS
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       reset_load,
    input  logic       reset_counter,
    input  logic       enable_counter,
    input  logic       count_x_enable,
    input  logic       colour_erase_enable,
    input  logic       ld_x,
    input  logic       ld_y,
    input  logic [2:0] colour_in,
    input  logic       key_stop,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       done_plot,
    output logic       enable_erase,
    output logic       stop_true
);

    import stacker_pkg::*;

    localparam int PW = $clog2(BLOCK_W * BLOCK_H);
    localparam int XB = $clog2(BLOCK_W);

    localparam logic [7:0] X_TURN = 8'(X_MAX - BLOCK_W);
    localparam logic [6:0] Y_HOME = 7'(Y_MAX - BLOCK_H);
    localparam logic [6:0] Y_STEP = 7'(BLOCK_H);

    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic          dir_q, dir_d;
    logic          placed_q, placed_d;
    logic [PW-1:0] pix_q;
    logic [1:0]    stop_q;

    assign stop_true = stop_q[1];

    // reset_load wins over moves; ld_y (when placed) overrides ld_x.
    // ld_y always clears placed, even if stop is still held.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        placed_d = placed_q | stop_true;
        if (!reset_load) begin
            x_d      = '0;
            y_d      = Y_HOME;
            dir_d    = 1'b0;
            placed_d = 1'b0;
        end else begin
            if (ld_x) begin
                if (!dir_q && x_q == X_TURN) begin
                    dir_d = 1'b1;
                    x_d   = x_q - 8'd1;
                end else if (dir_q && x_q == 8'd0) begin
                    dir_d = 1'b0;
                    x_d   = x_q + 8'd1;
                end else if (dir_q) begin
                    x_d = x_q - 8'd1;
                end else begin
                    x_d = x_q + 8'd1;
                end
            end
            if (ld_y) begin
                placed_d = 1'b0;
                if (placed_q) begin
                    x_d   = '0;
                    dir_d = 1'b0;
                    y_d   = (y_q < Y_STEP) ? Y_HOME : y_q - Y_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            x_q      <= '0;
            y_q      <= Y_HOME;
            dir_q    <= 1'b0;
            placed_q <= 1'b0;
            pix_q    <= '0;
            stop_q   <= 2'b00;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            placed_q <= placed_d;
            stop_q   <= {stop_q[0], ~key_stop};
            // Counter is a power of two wide, so +1 wraps at the last pixel.
            pix_q    <= count_x_enable ? pix_q + 1'b1 : '0;
        end
    end

    assign x_out      = x_q + 8'(pix_q[XB-1:0]);
    assign y_out      = y_q + 7'(pix_q[PW-1:XB]);
    assign done_plot  = count_x_enable && (pix_q == {PW{1'b1}});
    assign colour_out = colour_erase_enable ? COLOUR_BLACK : colour_in;

    rate_divider #(
        .FRAME_TICKS(FRAME_TICKS)
    ) u_rate (
        .clk           (clk),
        .resetn        (resetn),
        .reset_counter (reset_counter),
        .enable_counter(enable_counter),
        .enable_erase  (enable_erase)
    );

endmodule
